rect_pixel_resolver: RTL and testbench
======================================

Name: rect_pixel_resolver

Overview:
- Sequential stage directly upstream of the combinational rect/point comparator.
- For one pixel coordinate, it walks the rect table in index order and streams each rect's bounds into a comparator instance.
- Resolves the pixel colour painter-style: the highest-index hit wins, otherwise the background colour.
- Sits between the video timing/pixel generator (input handshake) and the pixel output FIFO (output handshake).

Parameters:
- COORD_WIDTH, 16, width of coordinates and rect bounds; all compared as signed.
- COLOR_WIDTH, 16, width of colour words.
- RECT_COUNT, 64, number of rect entries scanned per pixel; must be ≥1.
- ADDR_WIDTH, 6, rect table address width; must satisfy 2^ADDR_WIDTH ≥ RECT_COUNT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_x  in  COORD_WIDTH  pixel x, signed.
- in_y  in  COORD_WIDTH  pixel y, signed.
- bg_color  in  COLOR_WIDTH  background colour, sampled together with the request.
- rect_addr  out  ADDR_WIDTH  rect table read address.
- rect_rd_en  out  1  read strobe.
- rect_left / rect_top / rect_right / rect_bottom  in  COORD_WIDTH each  rect bounds, valid 1 cycle after the rect_rd_en address.
- rect_color  in  COLOR_WIDTH  rect colour, same timing as the bounds.
- out_valid  out  1  resolved colour valid.
- out_ready  in  1  consumer accepts.
- out_color  out  COLOR_WIDTH  resolved colour.
- out_hit  out  1  at least one rect covered the pixel.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_color=0, out_hit=0, rect_rd_en=0, rect_addr=0.
  - Internal index, latched x/y and latched bg_color are cleared to 0.
  - Reset asserted mid-scan or during DONE drops the pixel; no output is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_x, in_y, bg_color; set the working colour to bg_color and the hit flag to 0; go to SCAN.
  - In the same edge, drive rect_addr=0 with rect_rd_en=1.
- SCAN:
  - Cycle k (k=0..RECT_COUNT-1) issues address k.
  - Cycle k+1 compares the returned data for k against the latched x/y through the comparator sub-module.
  - On a hit, the working colour takes rect_color and the hit flag is set.
  - rect_rd_en drops after address RECT_COUNT-1 is issued.
  - After the compare of the last index, go to DONE.
- DONE:
  - out_valid=1; out_color and out_hit hold stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
  - out_ready held low stalls indefinitely, with no state change.
- Latency:
  - Request accept to out_valid rising = RECT_COUNT+1 cycles.
  - Throughput = one pixel per RECT_COUNT+3 cycles with out_ready tied high.
  - out_valid and in_ready are never high in the same cycle.
- Compare rule: left ≤ x < right and top ≤ y < bottom, signed COORD_WIDTH.
  - A degenerate rect (left≥right or top≥bottom) never hits.
  - Negative bounds and coords are legal.
- Overlap: a later index overwrites an earlier one.
- The address counter never wraps past RECT_COUNT-1.
- in_valid outside IDLE is ignored; the upstream holds the request until in_ready.

Decomposition:
- Shared package: rect field widths, the state encoding (IDLE, SCAN, DONE) and a default background constant.
- One sub-module, instantiated once: the existing comparator, combinational, fed by the registered read data and the latched coordinates.

Test Plan:
- RECT_COUNT=4, all rects degenerate (0,0,0,0), bg=0x1234, request (5,5):
  - out_color=0x1234, out_hit=0.
  - out_valid rises exactly 5 cycles after accept.
- Rect1=(0,0,10,10,color 0xAAAA), rect3=(5,5,20,20,color 0xBBBB), request (7,7):
  - out_color=0xBBBB, out_hit=1.
  - Request (2,2) → 0xAAAA; request (10,3) → bg (right edge is exclusive).
- Signed coords: rect0=(-8,-8,0,0,color 0x0F0F):
  - Request (-1,-1) → 0x0F0F.
  - Request (0,-1) → bg.
  - Request (0x7FFF,0) → bg.
- out_ready held low 20 cycles at DONE:
  - out_valid stays 1 and out_color stays stable; in_ready stays 0.
  - A new in_valid is not accepted until one cycle after out_ready.
- Assert rst_n=0 in the middle of SCAN:
  - All outputs return to reset values immediately.
  - After release, a fresh request resolves correctly with no stale colour.
- Back-to-back requests with out_ready=1:
  - Each pixel appears once, in order.
  - rect_addr sequence is 0..3 per pixel, with no reads while IDLE.

Source files
------------

// File: rtl/rect_pixel_resolver_pkg.sv
// Shared types and defaults for the rect pixel resolver: field widths,
// controller state encoding and the fallback background colour.
package rect_pixel_resolver_pkg;

    localparam int DEF_COORD_WIDTH = 16;
    localparam int DEF_COLOR_WIDTH = 16;
    localparam int DEF_RECT_COUNT  = 64;
    localparam int DEF_ADDR_WIDTH  = 6;

    localparam logic [DEF_COLOR_WIDTH-1:0] DEFAULT_BG = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_pixel_resolver_if.sv
// Pixel request, rect table read port and resolved-colour output of the
// resolver, bundled so the producer, table and consumer share one view.
interface rect_pixel_resolver_if
    import rect_pixel_resolver_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [COORD_WIDTH-1:0] in_x;
    logic signed [COORD_WIDTH-1:0] in_y;
    logic        [COLOR_WIDTH-1:0] bg_color;

    logic        [ADDR_WIDTH-1:0]  rect_addr;
    logic                          rect_rd_en;
    logic signed [COORD_WIDTH-1:0] rect_left;
    logic signed [COORD_WIDTH-1:0] rect_top;
    logic signed [COORD_WIDTH-1:0] rect_right;
    logic signed [COORD_WIDTH-1:0] rect_bottom;
    logic        [COLOR_WIDTH-1:0] rect_color;

    logic                          out_valid;
    logic                          out_ready;
    logic        [COLOR_WIDTH-1:0] out_color;
    logic                          out_hit;

    modport slave (
        input  in_valid, in_x, in_y, bg_color,
        input  rect_left, rect_top, rect_right, rect_bottom, rect_color,
        input  out_ready,
        output in_ready, rect_addr, rect_rd_en,
        output out_valid, out_color, out_hit
    );

    modport master (
        output in_valid, in_x, in_y, bg_color,
        output rect_left, rect_top, rect_right, rect_bottom, rect_color,
        output out_ready,
        input  in_ready, rect_addr, rect_rd_en,
        input  out_valid, out_color, out_hit
    );

endinterface

// File: rtl/rect_pixel_resolver_cmp.sv
// Combinational rect/point comparator: half-open box test on signed values,
// so an empty or inverted rect can never report a hit.
module rect_pixel_resolver_cmp #(
    parameter int COORD_WIDTH = 16
) (
    input  logic signed [COORD_WIDTH-1:0] x,
    input  logic signed [COORD_WIDTH-1:0] y,
    input  logic signed [COORD_WIDTH-1:0] left,
    input  logic signed [COORD_WIDTH-1:0] top,
    input  logic signed [COORD_WIDTH-1:0] right,
    input  logic signed [COORD_WIDTH-1:0] bottom,
    output logic                          hit
);

    assign hit = (left <= x) && (x < right) && (top <= y) && (y < bottom);

endmodule

// File: rtl/rect_pixel_resolver.sv
// Resolves one pixel at a time by streaming the whole rect table through the
// comparator; the last covering rect in index order supplies the colour.
module rect_pixel_resolver
    import rect_pixel_resolver_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int RECT_COUNT  = DEF_RECT_COUNT,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rect_pixel_resolver_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RECT_COUNT - 1);

    state_e                        state_q, state_d;
    logic        [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                          rd_en_q, rd_en_d;
    logic                          cmp_valid_q, cmp_valid_d;
    logic                          cmp_last_q, cmp_last_d;
    logic signed [COORD_WIDTH-1:0] x_q, x_d;
    logic signed [COORD_WIDTH-1:0] y_q, y_d;
    logic        [COLOR_WIDTH-1:0] bg_q, bg_d;
    logic        [COLOR_WIDTH-1:0] color_q, color_d;
    logic                          hit_q, hit_d;
    logic                          rect_hit;

    rect_pixel_resolver_cmp #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_cmp (
        .x      (x_q),
        .y      (y_q),
        .left   (bus.rect_left),
        .top    (bus.rect_top),
        .right  (bus.rect_right),
        .bottom (bus.rect_bottom),
        .hit    (rect_hit)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_en_d     = rd_en_q;
        cmp_valid_d = 1'b0;
        cmp_last_d  = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        bg_d        = bg_q;
        color_d     = color_q;
        hit_d       = hit_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    bg_d    = bus.bg_color;
                    color_d = bus.bg_color;
                    hit_d   = 1'b0;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Read data lags the address by one cycle, so the compare
                // qualifiers are the read strobe delayed by one stage.
                cmp_valid_d = rd_en_q;
                cmp_last_d  = rd_en_q && (addr_q == LAST_ADDR);
                if (rd_en_q) begin
                    if (addr_q == LAST_ADDR) begin
                        rd_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (cmp_valid_q && rect_hit) begin
                    color_d = bus.rect_color;
                    hit_d   = 1'b1;
                end
                if (cmp_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            bg_q        <= '0;
            color_q     <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_last_q  <= cmp_last_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bg_q        <= bg_d;
            color_q     <= color_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.rect_addr  = addr_q;
    assign bus.rect_rd_en = rd_en_q;
    assign bus.out_hit    = hit_q;
    // With no hit the latched background is the answer regardless of color_q.
    assign bus.out_color  = hit_q ? color_q : bg_q;

endmodule

// File: tb/tb_rect_pixel_resolver.sv
// Directed bench for rect_pixel_resolver with a 4-entry rect table model and
// a per-cycle comparison against a painter-order reference.
module tb_rect_pixel_resolver;

    localparam int RC = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rect_pixel_resolver_if #(.COORD_WIDTH(16), .COLOR_WIDTH(16), .ADDR_WIDTH(AW)) bus ();

    rect_pixel_resolver #(
        .COORD_WIDTH (16),
        .COLOR_WIDTH (16),
        .RECT_COUNT  (RC),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic signed [15:0] t_left [RC];
    logic signed [15:0] t_top [RC];
    logic signed [15:0] t_right [RC];
    logic signed [15:0] t_bottom [RC];
    logic        [15:0] t_color [RC];

    // Rect table with a one-cycle registered read.
    always @(posedge clk) begin
        if (bus.rect_rd_en) begin
            bus.rect_left   <= t_left[bus.rect_addr];
            bus.rect_top    <= t_top[bus.rect_addr];
            bus.rect_right  <= t_right[bus.rect_addr];
            bus.rect_bottom <= t_bottom[bus.rect_addr];
            bus.rect_color  <= t_color[bus.rect_addr];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    int acc_count = 0;
    bit prev_valid = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int acc_hist[$];
    int addr_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic signed [15:0] x, input logic signed [15:0] y,
                                  input logic [15:0] bg, output logic [15:0] c, output logic h);
        c = bg;
        h = 1'b0;
        for (int i = 0; i < RC; i++) begin
            if (t_left[i] <= x && x < t_right[i] && t_top[i] <= y && y < t_bottom[i]) begin
                c = t_color[i];
                h = 1'b1;
            end
        end
    endfunction

    // Posedge monitor: accepts feed the model, handshakes retire results.
    initial begin
        logic [15:0] mc;
        logic        mh;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                cyc++;
                if (bus.in_valid && bus.in_ready) begin
                    model(bus.in_x, bus.in_y, bus.bg_color, mc, mh);
                    exp_q.push_back({mh, mc});
                    acc_cyc = cyc;
                    acc_count++;
                    acc_hist.push_back(cyc);
                end
                if (bus.out_valid && bus.out_ready) begin
                    hs_cyc = cyc;
                    got_q.push_back({bus.out_hit, bus.out_color});
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (bus.rect_rd_en) addr_log.push_back(int'(bus.rect_addr));
            end
        end
    end

    // Negedge compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid_ready_excl", {31'd0, bus.out_valid & bus.in_ready}, 0);
                check("rd_while_idle", {31'd0, bus.rect_rd_en & bus.in_ready}, 0);
                if (bus.rect_rd_en) check("addr_range", {31'd0, bus.rect_addr < AW'(RC - 1) || bus.rect_addr == AW'(RC - 1)}, 1);
                if (bus.out_valid) begin
                    check("exp_pending", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        check("model_color", {16'd0, bus.out_color}, {16'd0, exp_q[0][15:0]});
                        check("model_hit", {31'd0, bus.out_hit}, {31'd0, exp_q[0][16]});
                    end
                    if (!prev_valid) check("latency", cyc - acc_cyc, RC + 1);
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    task automatic set_rect(input int i, input logic signed [15:0] l, input logic signed [15:0] t,
                            input logic signed [15:0] r, input logic signed [15:0] b, input logic [15:0] c);
        t_left[i] = l; t_top[i] = t; t_right[i] = r; t_bottom[i] = b; t_color[i] = c;
    endtask

    task automatic clear_rects();
        for (int i = 0; i < RC; i++) set_rect(i, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'h0000);
    endtask

    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, input logic [15:0] bg);
        int n = 0;
        @(negedge clk);
        bus.in_x = x; bus.in_y = y; bus.bg_color = bg; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, bus.in_ready}, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [15:0] ec, input logic eh);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_valid"}, {31'd0, bus.out_valid}, 1);
        check({nm, "_color"}, {16'd0, bus.out_color}, {16'd0, ec});
        check({nm, "_hit"}, {31'd0, bus.out_hit}, {31'd0, eh});
        $display("pixel %s color=0x%04h hit=%0d", nm, bus.out_color, bus.out_hit);
    endtask

    task automatic do_req(input string nm, input logic signed [15:0] x, input logic signed [15:0] y,
                          input logic [15:0] bg, input logic [15:0] ec, input logic eh);
        logic [15:0] mc;
        logic        mh;
        model(x, y, bg, mc, mh);
        check({nm, "_ref_color"}, {16'd0, mc}, {16'd0, ec});
        check({nm, "_ref_hit"}, {31'd0, mh}, {31'd0, eh});
        send(x, y, bg);
        wait_out(nm, ec, eh);
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.bg_color = '0; bus.out_ready = 1'b1;
        clear_rects();
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_color", {16'd0, bus.out_color}, 0);
        check("rst_out_hit", {31'd0, bus.out_hit}, 0);
        check("rst_rd_en", {31'd0, bus.rect_rd_en}, 0);
        check("rst_addr", {30'd0, bus.rect_addr}, 0);
        rst_n = 1'b1;

        do_req("degenerate", 16'sd5, 16'sd5, 16'h1234, 16'h1234, 1'b0);

        set_rect(1, 16'sd0, 16'sd0, 16'sd10, 16'sd10, 16'hAAAA);
        set_rect(3, 16'sd5, 16'sd5, 16'sd20, 16'sd20, 16'hBBBB);
        do_req("overlap_7_7", 16'sd7, 16'sd7, 16'h1234, 16'hBBBB, 1'b1);
        do_req("overlap_2_2", 16'sd2, 16'sd2, 16'h1234, 16'hAAAA, 1'b1);
        do_req("right_edge", 16'sd10, 16'sd3, 16'h1234, 16'h1234, 1'b0);

        clear_rects();
        set_rect(0, -16'sd8, -16'sd8, 16'sd0, 16'sd0, 16'h0F0F);
        do_req("neg_in", -16'sd1, -16'sd1, 16'h1234, 16'h0F0F, 1'b1);
        do_req("neg_edge", 16'sd0, -16'sd1, 16'h1234, 16'h1234, 1'b0);
        do_req("max_x", 16'sh7FFF, 16'sd0, 16'h1234, 16'h1234, 1'b0);

        // Output stall with a competing request held at the input.
        clear_rects();
        set_rect(1, 16'sd0, 16'sd0, 16'sd10, 16'sd10, 16'hAAAA);
        set_rect(3, 16'sd5, 16'sd5, 16'sd20, 16'sd20, 16'hBBBB);
        bus.out_ready = 1'b0;
        send(16'sd7, 16'sd7, 16'h1234);
        wait_out("stall", 16'hBBBB, 1'b1);
        bus.in_x = 16'sd2; bus.in_y = 16'sd2; bus.bg_color = 16'h1234; bus.in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.out_valid}, 1);
            check("stall_color", {16'd0, bus.out_color}, 32'h0000BBBB);
            check("stall_in_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        n = acc_count;
        for (int k = 0; k < 10 && acc_count == n; k++) @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_accept_gap", acc_cyc - hs_cyc, 1);
        wait_out("stall_next", 16'hAAAA, 1'b1);
        @(negedge clk);

        // Reset in the middle of a scan.
        send(16'sd7, 16'sd7, 16'h1234);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        check("midrst_out_color", {16'd0, bus.out_color}, 0);
        check("midrst_out_hit", {31'd0, bus.out_hit}, 0);
        check("midrst_rd_en", {31'd0, bus.rect_rd_en}, 0);
        check("midrst_addr", {30'd0, bus.rect_addr}, 0);
        exp_q.delete();
        prev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req("post_rst_hit", 16'sd2, 16'sd2, 16'h5555, 16'hAAAA, 1'b1);
        do_req("post_rst_bg", 16'sd10, 16'sd3, 16'h5555, 16'h5555, 1'b0);

        // Back-to-back with the consumer always ready.
        addr_log.delete();
        acc_hist.delete();
        got_q.delete();
        send(16'sd7, 16'sd7, 16'h1234);
        send(16'sd2, 16'sd2, 16'h1234);
        send(16'sd10, 16'sd3, 16'h1234);
        for (int k = 0; k < 50 && got_q.size() < 3; k++) @(negedge clk);
        check("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_px0", {15'd0, got_q[0]}, 32'h0001BBBB);
            check("b2b_px1", {15'd0, got_q[1]}, 32'h0001AAAA);
            check("b2b_px2", {15'd0, got_q[2]}, 32'h00001234);
        end
        check("b2b_reads", addr_log.size(), 3 * RC);
        for (int i = 0; i < addr_log.size(); i++) check("b2b_addr_seq", addr_log[i], i % RC);
        if (acc_hist.size() == 3) begin
            check("b2b_period0", acc_hist[1] - acc_hist[0], RC + 3);
            check("b2b_period1", acc_hist[2] - acc_hist[1], RC + 3);
        end else begin
            check("b2b_accepts", acc_hist.size(), 3);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
